// File: rtl/reset_seq_pkg.sv
// Shared clocking definitions: reset-sequencer state encoding, counter sizing helper,
// and the registered output bundle.
package reset_seq_pkg;

   localparam int RELOCK_W = 8;

   localparam logic [2:0] ST_WAIT_LOCK = 3'd0;
   localparam logic [2:0] ST_FILTER    = 3'd1;
   localparam logic [2:0] ST_HOLD      = 3'd2;
   localparam logic [2:0] ST_STAGGER   = 3'd3;
   localparam logic [2:0] ST_RUN       = 3'd4;

   typedef struct packed {
      logic rst_mem;
      logic rst_core;
      logic ready;
   } rst_out_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/reset_seq_if.sv
// PLL lock input and staged reset outputs of the reset sequencer.
interface reset_seq_if;
   import reset_seq_pkg::*;

   logic                pll_reset;
   logic                rst_mem;
   logic                rst_core;
   logic                ready;
   logic [RELOCK_W-1:0] relock_count;

   modport master (output pll_reset, input rst_mem, rst_core, ready, relock_count);
   modport slave  (input pll_reset, output rst_mem, rst_core, ready, relock_count);
endinterface

// File: rtl/reset_seq_bit_sync.sv
// Single-bit multi-flop synchronizer with a configurable synchronous reset value.
module bit_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) sync_q <= {STAGES{RST_VAL}};
      else       sync_q <= {sync_q[STAGES-2:0], d_i};
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/reset_seq.sv
// Reset sequencer: qualifies PLL lock, then releases rst_mem followed by rst_core,
// and falls back to full reset on any lock loss.
module reset_seq
   import reset_seq_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int LOCK_CYCLES    = 1024,
   parameter int HOLD_CYCLES    = 16,
   parameter int STAGGER_CYCLES = 8
) (
   input  logic        clock,
   input  logic        reset,
   reset_seq_if.slave  bus
);

   localparam int CNT_W    = $clog2(max3(LOCK_CYCLES, HOLD_CYCLES, STAGGER_CYCLES)) + 1;
   localparam int STG_LAST = (STAGGER_CYCLES > 0) ? STAGGER_CYCLES - 1 : 0;

   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STG_LAST);

   logic                s;
   logic [2:0]          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [RELOCK_W-1:0] relock_q, relock_d;
   rst_out_t            out_q, out_d;

   // Flops reset to 1 so the FSM sees "unlocked" until the PLL state is actually sampled.
   bit_sync #(
      .STAGES  (SYNC_STAGES),
      .RST_VAL (1'b1)
   ) u_sync (
      .clk_i (clock),
      .rst_i (reset),
      .d_i   (bus.pll_reset),
      .q_o   (s)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      relock_d = relock_q;
      case (state_q)
         ST_WAIT_LOCK: begin
            if (!s) begin
               state_d = ST_FILTER;
               cnt_d   = '0;
            end
         end
         ST_FILTER: begin
            if (cnt_q == LOCK_LAST) begin
               state_d = ST_HOLD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               state_d = (STAGGER_CYCLES == 0) ? ST_RUN : ST_STAGGER;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_STAGGER: begin
            if (cnt_q == STAG_LAST) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RUN: ;
         default: begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
         end
      endcase

      // Lock loss overrides any expiry decided above.
      if (s && state_q != ST_WAIT_LOCK) begin
         state_d = ST_WAIT_LOCK;
         cnt_d   = '0;
         if (state_q == ST_RUN && relock_q != '1)
            relock_d = relock_q + RELOCK_W'(1);
      end
   end

   always_comb begin
      out_d          = '0;
      out_d.rst_mem  = !(state_d == ST_STAGGER || state_d == ST_RUN);
      out_d.rst_core = (state_d != ST_RUN);
      out_d.ready    = (state_d == ST_RUN);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= ST_WAIT_LOCK;
         cnt_q    <= '0;
         relock_q <= '0;
         out_q    <= '{rst_mem: 1'b1, rst_core: 1'b1, ready: 1'b0};
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         relock_q <= relock_d;
         out_q    <= out_d;
      end
   end

   assign bus.rst_mem      = out_q.rst_mem;
   assign bus.rst_core     = out_q.rst_core;
   assign bus.ready        = out_q.ready;
   assign bus.relock_count = relock_q;

endmodule
